// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/DMA bus arbiter with WAIT_CYC wait states and bounded DMA starvation; `define ARB_PERF_CNT_EN adds perf counters
module bus_arbiter #(
    parameter int WAIT_CYC   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        cpu_req,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wen,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] Bus_addr,
    output logic        Bus_wen,
    output logic [31:0] Bus_wdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_dma_grants,
`endif
    input  logic [31:0] Bus_rdata
);
    localparam logic [3:0] WAIT_LD    = 4'(WAIT_CYC);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DMA} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, starve_cnt;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_wen;
    logic        busy, cpu_win, dma_win, cpu_grant, dma_grant;

    assign busy      = state != IDLE;
    assign cpu_win   = cpu_req && !(dma_req && starve_cnt == STARVE_LIM);
    assign dma_win   = dma_req && !cpu_win;
    assign cpu_grant = !busy && cpu_win;
    assign dma_grant = !busy && dma_win;

    // state, wait counter, starvation counter and latched winner request
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wen    <= 1'b0;
        end else begin
            state <= state_nx;
            if (cpu_grant || dma_grant) begin
                cnt       <= WAIT_LD;
                lat_addr  <= cpu_win ? cpu_addr : dma_addr;
                lat_wdata <= cpu_win ? cpu_wdata : dma_wdata;
                lat_wen   <= cpu_win ? cpu_wen : dma_wen;
            end else if (busy) begin
                cnt <= cnt - 4'd1;
            end
            starve_cnt <= (!dma_req || dma_grant) ? '0 :
                          (cpu_grant && starve_cnt != STARVE_LIM) ? starve_cnt + 4'd1 : starve_cnt;
        end
    end

    // arbitrate in IDLE, return to IDLE once the wait count expires
    always_comb begin
        state_nx = !busy ? (cpu_win ? BUSY_CPU : dma_win ? BUSY_DMA : IDLE) :
                   (cnt == 4'd0 ? IDLE : state);
    end

    // bus drive from latched request only; write strobe on the first busy cycle
    always_comb begin
        Bus_addr  = busy ? lat_addr : '0;
        Bus_wdata = busy ? lat_wdata : '0;
        Bus_wen   = busy && lat_wen && cnt == WAIT_LD;
        cpu_done  = state == BUSY_CPU && cnt == 4'd0;
        dma_ack   = state == BUSY_DMA && cnt == 4'd0;
        cpu_rdata = Bus_rdata;
        dma_rdata = Bus_rdata;
        cpu_stall = cpu_req && !cpu_done;
    end

`ifdef ARB_PERF_CNT_EN
    // stall-cycle and DMA-grant counters, wrapping modulo 2^32
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            perf_stall_cyc  <= '0;
            perf_dma_grants <= '0;
        end else begin
            perf_stall_cyc  <= perf_stall_cyc + 32'(cpu_stall);
            perf_dma_grants <= perf_dma_grants + 32'(dma_grant);
        end
    end
`endif
endmodule
